// File: rtl/keypad_scanner_pkg.sv
// Shared definitions for the keypad scanner and the calculator front end:
// key codes, the eBCD strobe bit position, scanner FSM states and
// small helpers for decoding one-cold row/column vectors.
package keypad_scanner_pkg;

  // Non-digit key codes, shared with the calculator interface
  localparam logic [3:0] KEY_DIVMOD = 4'hA;
  localparam logic [3:0] KEY_TIMES  = 4'hB;
  localparam logic [3:0] KEY_SIGN   = 4'hC;
  localparam logic [3:0] KEY_NONE   = 4'hD;
  localparam logic [3:0] KEY_ANS    = 4'hE;
  localparam logic [3:0] KEY_EQU    = 4'hF;

  // Bit of eBCD that carries the key strobe
  localparam int EBCD_STB_IDX = 4;

  typedef enum logic [2:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_SETUP,
    ST_STROBE,
    ST_RELEASE
  } scan_state_t;

  // True when exactly one bit of an active-low vector is low
  function automatic logic one_low(input logic [3:0] v);
    return (v == 4'b1110) || (v == 4'b1101) || (v == 4'b1011) || (v == 4'b0111);
  endfunction

  // Index of the low bit of a one-cold vector (lowest low bit wins)
  function automatic logic [1:0] low_index(input logic [3:0] v);
    logic [1:0] idx;
    if (!v[0])      idx = 2'd0;
    else if (!v[1]) idx = 2'd1;
    else if (!v[2]) idx = 2'd2;
    else            idx = 2'd3;
    return idx;
  endfunction

endpackage

// File: rtl/keypad_keymap.sv
// Combinational keypad map: {row, column} position to 4-bit key code.
module keypad_keymap
  import keypad_scanner_pkg::*;
(
  input  logic [1:0] i_row_idx,
  input  logic [1:0] i_col_idx,
  output logic [3:0] o_code
);

  // Physical layout of the calculator keypad
  always_comb begin
    o_code = KEY_NONE;
    case ({i_row_idx, i_col_idx})
      4'b00_00: o_code = 4'h1;
      4'b00_01: o_code = 4'h2;
      4'b00_10: o_code = 4'h3;
      4'b00_11: o_code = KEY_DIVMOD;
      4'b01_00: o_code = 4'h4;
      4'b01_01: o_code = 4'h5;
      4'b01_10: o_code = 4'h6;
      4'b01_11: o_code = KEY_TIMES;
      4'b10_00: o_code = 4'h7;
      4'b10_01: o_code = 4'h8;
      4'b10_10: o_code = 4'h9;
      4'b10_11: o_code = KEY_SIGN;
      4'b11_00: o_code = KEY_ANS;
      4'b11_01: o_code = 4'h0;
      4'b11_10: o_code = KEY_EQU;
      4'b11_11: o_code = KEY_NONE;
      default:  o_code = KEY_NONE;
    endcase
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column scan, debounce, multi-key rejection and
// one eBCD event (code + strobe) per key press. After reset the scanner
// stays disarmed until one full column rotation reads all rows high, so a
// key still held across reset never produces an event.
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int SCAN_DIV   = 1000,
  parameter int DEBOUNCE_N = 4,
  parameter int STROBE_LEN = 2
) (
  input  logic       sw_clk,
  input  logic       rst,
  input  logic [3:0] key_row,
  output logic [3:0] key_col,
  output logic [4:0] eBCD,
  output logic       key_busy
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DEB_W = $clog2(DEBOUNCE_N + 1);
  localparam int STB_W = $clog2(STROBE_LEN + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_N);
  localparam logic [DEB_W-1:0] DEB_PRE  = DEB_W'(DEBOUNCE_N - 1);
  localparam logic [STB_W-1:0] STB_LAST = STB_W'(STROBE_LEN);

  scan_state_t      r_state;
  logic [DIV_W-1:0] r_div;
  logic [DEB_W-1:0] r_deb_cnt;
  logic [STB_W-1:0] r_stb_cnt;
  logic [3:0]       r_key_col;
  logic [3:0]       r_row;
  logic [1:0]       r_row_idx;
  logic [1:0]       r_col_idx;
  logic [3:0]       r_code;
  logic             r_stb;
  logic             r_busy;
  logic             r_armed;
  logic [1:0]       r_arm_cnt;

  logic             w_sample;
  logic             w_row_valid;
  logic             w_row_idle;
  logic [3:0]       w_code;

  assign w_sample    = (r_div == DIV_LAST);
  assign w_row_valid = one_low(key_row);
  assign w_row_idle  = (key_row == 4'hF);

  keypad_keymap u_keymap (
    .i_row_idx (r_row_idx),
    .i_col_idx (r_col_idx),
    .o_code    (w_code)
  );

  // Free-running slot divider; rows are sampled on its last count
  always_ff @(posedge sw_clk or negedge rst) begin
    if (!rst) begin
      r_div <= '0;
    end else if (w_sample) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  // Scan / debounce / strobe / release sequencing with registered outputs
  always_ff @(posedge sw_clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_SCAN;
      r_deb_cnt <= '0;
      r_stb_cnt <= '0;
      r_key_col <= 4'b1110;
      r_row     <= 4'hF;
      r_row_idx <= 2'd0;
      r_col_idx <= 2'd0;
      r_code    <= 4'h0;
      r_stb     <= 1'b0;
      r_busy    <= 1'b0;
      r_armed   <= 1'b0;
      r_arm_cnt <= 2'd0;
    end else begin
      case (r_state)
        ST_SCAN: begin
          if (w_sample) begin
            if (w_row_valid && r_armed) begin
              // Candidate press: freeze the column and start debouncing
              r_row     <= key_row;
              r_row_idx <= low_index(key_row);
              r_col_idx <= low_index(r_key_col);
              r_deb_cnt <= DEB_W'(1);
              r_state   <= ST_DEBOUNCE;
            end else begin
              r_key_col <= {r_key_col[2:0], r_key_col[3]};
              // Arm once every column has read all rows high in a row
              if (!r_armed) begin
                if (w_row_idle) begin
                  if (r_arm_cnt == 2'd3) begin
                    r_armed <= 1'b1;
                  end else begin
                    r_arm_cnt <= r_arm_cnt + 2'd1;
                  end
                end else begin
                  r_arm_cnt <= 2'd0;
                end
              end
            end
          end
        end

        ST_DEBOUNCE: begin
          if (r_deb_cnt == DEB_LAST) begin
            // Only reachable when a single sample is enough
            r_code  <= w_code;
            r_busy  <= 1'b1;
            r_state <= ST_SETUP;
          end else if (w_sample) begin
            if (key_row == r_row) begin
              if (r_deb_cnt == DEB_PRE) begin
                r_code  <= w_code;
                r_busy  <= 1'b1;
                r_state <= ST_SETUP;
              end
              r_deb_cnt <= r_deb_cnt + DEB_W'(1);
            end else begin
              r_deb_cnt <= '0;
              r_state   <= ST_SCAN;
            end
          end
        end

        ST_SETUP: begin
          r_deb_cnt <= '0;
          if (r_code == KEY_NONE) begin
            // Unused key: hold busy until release, but never strobe
            r_state <= ST_RELEASE;
          end else begin
            r_stb     <= 1'b1;
            r_stb_cnt <= STB_W'(1);
            r_state   <= ST_STROBE;
          end
        end

        ST_STROBE: begin
          if (r_stb_cnt == STB_LAST) begin
            r_stb     <= 1'b0;
            r_stb_cnt <= '0;
            r_state   <= ST_RELEASE;
          end else begin
            r_stb_cnt <= r_stb_cnt + STB_W'(1);
          end
        end

        ST_RELEASE: begin
          if (w_sample) begin
            if (w_row_idle) begin
              if (r_deb_cnt == DEB_PRE) begin
                r_busy    <= 1'b0;
                r_deb_cnt <= '0;
                r_state   <= ST_SCAN;
              end else begin
                r_deb_cnt <= r_deb_cnt + DEB_W'(1);
              end
            end else begin
              r_deb_cnt <= '0;
            end
          end
        end

        default: begin
          r_state <= ST_SCAN;
        end
      endcase
    end
  end

  assign key_col                  = r_key_col;
  assign eBCD[EBCD_STB_IDX]       = r_stb;
  assign eBCD[EBCD_STB_IDX-1:0]   = r_code;
  assign key_busy                 = r_busy;

endmodule
